// File: rtl/capture_ctrl.sv
// capture_ctrl: arms a capture FIFO (reset pulse, wait for write side ready), captures N ADC words on trigger, drains.
// Latency: adc_data -> fifo_din through one register stage; fifo_wr_en is combinational on that registered sample.
// Backpressure: fifo_full drops the registered sample and sets sticky overflow; there is no stall or replay.
// Ports: wr_clk/rst_n clock and synchronous active-low reset; arm/trig/abort sequence control;
//        num_samples capture length (latched on accepted arm); adc_data/adc_valid sample input;
//        fifo_rst/fifo_wr_en/fifo_din and fifo_full/fifo_wr_empty/fifo_wr_rst_busy FIFO write side;
//        busy/done/overflow/sample_cnt status.
module capture_ctrl #(
    parameter int RST_CYCLES  = 8,
    parameter int DRAIN_GUARD = 4
) (
    input  logic        wr_clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        trig,
    input  logic        abort,
    input  logic [15:0] num_samples,
    input  logic [15:0] adc_data,
    input  logic        adc_valid,
    input  logic        fifo_full,
    input  logic        fifo_wr_empty,
    input  logic        fifo_wr_rst_busy,
    output logic        fifo_rst,
    output logic        fifo_wr_en,
    output logic [15:0] fifo_din,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] sample_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_WAIT_RDY,
        S_ARMED,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    localparam logic [15:0] LP_RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] LP_GUARD    = 16'(DRAIN_GUARD);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_tmr;        // cycles spent in the current state (FLUSH length, DRAIN guard)
    logic [15:0] r_n;
    logic [15:0] r_cnt;
    logic [15:0] r_data_q;
    logic        r_valid_q;
    logic        r_overflow;
    logic        r_done;

    logic        w_accept;     // arm taken in IDLE
    logic        w_zero;       // arm with zero length: finish immediately
    logic        w_wr_en;
    logic        w_drop;
    logic        w_finish;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_zero   = 1'b0;
        w_wr_en  = 1'b0;
        w_drop   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                // abort outranks arm even while idle
                if (arm && !abort) begin
                    w_accept = 1'b1;
                    if (num_samples == 16'd0) begin
                        w_zero = 1'b1;
                    end else begin
                        w_next = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (r_tmr == LP_RST_LAST) begin
                    w_next = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (!fifo_wr_rst_busy) begin
                    w_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (trig) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (r_valid_q && (r_cnt < r_n)) begin
                    if (fifo_full) begin
                        w_drop = 1'b1;
                    end else begin
                        w_wr_en = 1'b1;
                        if ((r_cnt + 16'd1) == r_n) begin
                            w_next = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                // the empty flag lags the last writes, so it is not trusted until the guard expires
                if (abort) begin
                    w_next = S_IDLE;
                end else if ((r_tmr >= LP_GUARD) && fifo_wr_empty) begin
                    w_next   = S_IDLE;
                    w_finish = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (!rst_n) begin
            r_tmr <= 16'd0;
        end else if (w_next != r_state) begin
            r_tmr <= 16'd0;
        end else if (r_tmr != 16'hFFFF) begin
            r_tmr <= r_tmr + 16'd1;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (!rst_n) begin
            r_valid_q  <= 1'b0;
            r_data_q   <= 16'd0;
            r_n        <= 16'd0;
            r_cnt      <= 16'd0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_valid_q <= adc_valid;
            r_data_q  <= adc_data;
            // done is registered: it rises on the same edge that returns the FSM to IDLE
            r_done    <= w_zero | w_finish;
            if (w_accept) begin
                r_n        <= num_samples;
                r_cnt      <= 16'd0;
                r_overflow <= 1'b0;
            end
            if (w_wr_en) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign fifo_rst   = (r_state == S_FLUSH);
    assign fifo_wr_en = w_wr_en;
    assign fifo_din   = r_data_q;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign sample_cnt = r_cnt;

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 8: number of cycles fifo_rst is held high per arm.
REQ-002 SHALL have parameter DRAIN_GUARD, default 4: number of DRAIN cycles during which fifo_wr_empty is ignored.
REQ-003 SHALL have port wr_clk, in, 1: single clock; all logic rises on this edge.
REQ-004 SHALL have port rst_n, in, 1: synchronous, active-low reset.
REQ-005 SHALL have port arm, in, 1: request to start a capture sequence.
REQ-006 SHALL have port trig, in, 1: capture trigger, level-sampled.
REQ-007 SHALL have port abort, in, 1: cancels any sequence.
REQ-008 SHALL have port num_samples, in, 16: words to capture; latched on accepted arm.
REQ-009 SHALL have port adc_data, in, 16: sample word.
REQ-010 SHALL have port adc_valid, in, 1: qualifies adc_data.
REQ-011 SHALL have port fifo_full, in, 1: FIFO write-side full.
REQ-012 SHALL have port fifo_wr_empty, in, 1: FIFO empty, already synchronized to wr_clk.
REQ-013 SHALL have port fifo_wr_rst_busy, in, 1: FIFO write-side reset in progress.
REQ-014 SHALL have port fifo_rst, out, 1: FIFO reset, active-high.
REQ-015 SHALL have port fifo_wr_en, out, 1: FIFO write enable.
REQ-016 SHALL have port fifo_din, out, 16: FIFO write data.
REQ-017 SHALL have port busy, out, 1: high in any state other than IDLE.
REQ-018 SHALL have port done, out, 1: one-cycle completion pulse.
REQ-019 SHALL have port overflow, out, 1: sticky flag for a dropped sample.
REQ-020 SHALL have port sample_cnt, out, 16: words written in the current capture.

Function
REQ-021 SHALL implement the states IDLE, FLUSH, WAIT_RDY, ARMED, CAPTURE, DRAIN.
REQ-022 IDLE + arm=1: SHALL latch num_samples, clear sample_cnt and overflow, and go to FLUSH; arm in any other state SHALL be ignored.
REQ-023 IDLE + arm=1 with num_samples=0: SHALL go to IDLE, pulse done the next cycle, and perform no FIFO reset or writes.
REQ-024 FLUSH: fifo_rst SHALL be high for exactly RST_CYCLES cycles, then the block SHALL go to WAIT_RDY.
REQ-025 WAIT_RDY: SHALL stay until fifo_wr_rst_busy=0 (observed no earlier than the first WAIT_RDY cycle), then go to ARMED.
REQ-026 ARMED + trig=1: SHALL go to CAPTURE; adc_data/adc_valid presented in the trigger cycle SHALL be the first eligible sample.
REQ-027 Input stage: adc_data and adc_valid SHALL be registered every cycle (valid_q, data_q); fifo_din SHALL equal data_q, a 1-cycle latency.
REQ-028 fifo_wr_en SHALL be combinational: valid_q AND NOT fifo_full AND state=CAPTURE AND sample_cnt<latched N AND NOT abort.
REQ-029 Each fifo_wr_en cycle SHALL increment sample_cnt by 1; the write that makes sample_cnt equal N SHALL move the state to DRAIN.
REQ-030 In CAPTURE, valid_q=1 with fifo_full=1 SHALL drop the sample, set overflow, and leave sample_cnt unchanged.
REQ-031 In CAPTURE, valid_q=0 SHALL produce no write and no count change.
REQ-032 DRAIN: SHALL ignore fifo_wr_empty for DRAIN_GUARD cycles, then on fifo_wr_empty=1 go to IDLE and pulse done in that transition cycle.
REQ-033 abort=1 in any non-IDLE state: SHALL go to IDLE next cycle with fifo_wr_en low in the abort cycle; no done pulse; overflow and sample_cnt held.
REQ-034 arm and abort both high in IDLE: abort SHALL win and the arm SHALL be ignored.
REQ-035 trig outside ARMED SHALL be ignored.
REQ-036 sample_cnt SHALL never wrap; it SHALL hold after reaching N.

Reset
REQ-037 rst_n=0 at a clock edge SHALL force state IDLE and set fifo_rst, fifo_wr_en, busy, done, overflow and sample_cnt to 0, and valid_q to 0.
REQ-038 Reset asserted mid-sequence SHALL take effect at the same edge and override all other inputs.

Verification
REQ-039 Bench SHALL cover: arm with num_samples=4, trig, adc_valid continuous with data 0x0001..0x0006, fifo_full=0 -> fifo_din 0x0001..0x0004 written on 4 consecutive cycles, sample_cnt=4, then DRAIN.
REQ-040 Bench SHALL cover: arm -> fifo_rst high exactly 8 cycles; fifo_wr_rst_busy held high 5 more cycles -> ARMED entered only after it falls.
REQ-041 Bench SHALL cover: CAPTURE with fifo_full=1 for 2 valid cycles -> 2 samples dropped, overflow=1, sample_cnt unchanged, capture continues after full clears.
REQ-042 Bench SHALL cover: fifo_wr_empty held 1 throughout DRAIN -> done pulses exactly once, on DRAIN cycle 5 (after the 4-cycle guard), busy falls the same edge.
REQ-043 Bench SHALL cover: abort during CAPTURE at sample_cnt=2 -> no further writes, IDLE next cycle, done stays 0.
REQ-044 Bench SHALL cover: arm with num_samples=0 -> done pulse, fifo_rst never asserted, no fifo_wr_en.
